decoder_scan_nx: RTL and testbench
==================================

// Module: decoder_scan_nx
// PURPOSE
// - Parametrised SEL_W-to-2^SEL_W one-hot decoder, registered, with an autonomous scan mode.
// - DIRECT mode decodes a handshaked select. SCAN mode walks a single one across all outputs with programmable dwell.
// - Sits between control logic and row/enable lines: display digit strobes, keypad row drive, bank selects.
// PARAMETERS
// - SEL_W    default 2  select width; output width OUT_W = 2**SEL_W (legal 1..6)
// - DWELL_W  default 8  dwell-count width; each scan position is held dwell+1 cycles
// PORTS
// - clk        in   1        single clock; all logic on rising edge
// - rst        in   1        asynchronous, active-high reset
// - en         in   1        block enable; 0 forces IDLE
// - mode       in   1        0 = DIRECT, 1 = SCAN
// - sel        in   SEL_W    select to decode (DIRECT)
// - sel_valid  in   1        sel is valid
// - sel_ready  out  1        block accepts sel this cycle
// - dwell      in   DWELL_W  hold count per scan position (SCAN)
// - y          out  OUT_W    registered one-hot output
// - y_valid    out  1        y holds a decoded/scan value
// - scan_idx   out  SEL_W    index of the active output bit
// - scan_wrap  out  1        one-cycle pulse on scan wrap OUT_W-1 -> 0
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, y=0, y_valid=0, scan_idx=0, scan_wrap=0, dwell counter=0.
// - FSM states: IDLE, DIRECT, SCAN. Transitions are evaluated every cycle:
//   - en=0 -> IDLE. In IDLE: y=0, y_valid=0, scan_wrap=0; scan_idx holds its value.
//   - en=1 & mode=0 -> DIRECT.
//   - en=1 & mode=1 -> SCAN.
// - sel_ready = en & ~mode (combinational). Handshake occurs when sel_valid & sel_ready.
// - DIRECT:
//   - On handshake: y <= 1<<sel, scan_idx <= sel, y_valid <= 1. Latency is 1 cycle.
//   - No handshake: y, y_valid, scan_idx hold.
//   - Entering DIRECT from SCAN holds the last scan value until the first handshake.
// - SCAN:
//   - Entry from IDLE or DIRECT: scan_idx=0, y=1, y_valid=1 on the first SCAN cycle. Counter loads dwell.
//   - Each cycle the counter decrements. At 0: scan_idx <= scan_idx+1 (mod OUT_W), y rotates left by 1, counter reloads dwell.
//   - dwell is sampled only at load, so mid-position changes take effect at the next position.
//   - dwell=0: advance every cycle.
//   - scan_wrap=1 in the cycle y becomes 1 via wrap from bit OUT_W-1. Never on SCAN entry.
// - y is always one-hot or zero. It is never multi-hot, including across mode changes.
// - Reset mid-scan: outputs clear immediately (async). After release, the block resumes from IDLE per en/mode.
// - SEL_W=1: OUT_W=2; scan alternates 01,10 and wraps every 2 positions.
// CONFIGURATION
// - DECODER_ACTIVE_LOW_EN defined: the y port is the bitwise inverse of the internal one-hot.
//   - Reset/IDLE value becomes all ones; the active bit is 0 (one-cold).
// - Not defined: y is active-high, as specified above.
// - All other outputs are unaffected by the macro.
// STRUCTURE
// - Package decoder_pkg:
//   - state enum dec_state_t {IDLE, DIRECT, SCAN}
//   - mode localparams MODE_DIRECT=0, MODE_SCAN=1
// - Sub-module decoder_dwell_cnt (DWELL_W):
//   - inputs: load, load value, decrement enable
//   - output: expire
//   - The top instantiates it once.
// - The top holds the FSM, the one-hot register and scan_idx.
// TESTING
// - SEL_W=2, DIRECT, sel=2 with valid -> next cycle y=4'b0100, y_valid=1, scan_idx=2; sel_valid=0 -> y holds.
// - SCAN, dwell=0 -> y=0001,0010,0100,1000,0001 on consecutive cycles; scan_wrap=1 only with the second 0001.
// - SCAN, dwell=3 -> each bit held 4 cycles. Change dwell to 1 mid-position -> the next position is held 2 cycles.
// - en=0 during SCAN -> y=0, y_valid=0 next cycle. en=1 again -> restart at y=0001, no scan_wrap.
// - Assert rst mid-scan (y=0100) -> y=0 and y_valid=0 without waiting for clk. After release with en=1, mode=1 -> y=0001.
// - DECODER_ACTIVE_LOW_EN, DIRECT, sel=1 -> y=4'b1101. Reset value of y = 4'b1111.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types for the one-hot decoder/scanner: FSM state encoding and mode values.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } dec_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : decoder_pkg

// File: rtl/decoder_dwell_cnt.sv
// Dwell down-counter for scan mode: loads a hold count, decrements, flags expiry at zero.
module decoder_dwell_cnt #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_dec_en,
  output logic               o_expire
);

  logic [DWELL_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule : decoder_dwell_cnt

// File: rtl/decoder_scan_nx.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with autonomous scan mode.
// Define DECODER_ACTIVE_LOW_EN to drive y one-cold (bitwise inverse of the internal one-hot).
module decoder_scan_nx
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   y,
  output logic                  y_valid,
  output logic [SEL_W-1:0]      scan_idx,
  output logic                  scan_wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  dec_state_t       r_state;
  dec_state_t       w_next_state;
  logic [OUT_W-1:0] r_y;
  logic             r_y_valid;
  logic [SEL_W-1:0] r_scan_idx;
  logic             r_scan_wrap;
  logic             w_handshake;
  logic             w_scan_entry;
  logic             w_scan_stay;
  logic             w_expire;
  logic             w_idx_last;

  assign sel_ready   = en & (mode == MODE_DIRECT);
  assign w_handshake = sel_valid & sel_ready;
  assign w_idx_last  = (r_scan_idx == {SEL_W{1'b1}});

  // NOTE: default first so every path assigns the next state and no latch is inferred.
  always_comb begin
    w_next_state = IDLE;
    if (en) begin
      w_next_state = (mode == MODE_SCAN) ? SCAN : DIRECT;
    end
  end

  assign w_scan_entry = (w_next_state == SCAN) && (r_state != SCAN);
  assign w_scan_stay  = (w_next_state == SCAN) && (r_state == SCAN);

  decoder_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_scan_entry | (w_scan_stay & w_expire)),
    .i_load_val(dwell),
    .i_dec_en  (w_scan_stay & ~w_expire),
    .o_expire  (w_expire)
  );

  // Outputs are keyed on the next state so a mode change is visible one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_y         <= '0;
      r_y_valid   <= 1'b0;
      r_scan_idx  <= '0;
      r_scan_wrap <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_scan_wrap <= 1'b0;
      unique case (w_next_state)
        IDLE: begin
          r_y       <= '0;
          r_y_valid <= 1'b0;
        end
        DIRECT: begin
          if (w_handshake) begin
            r_y        <= ONE << sel;
            r_scan_idx <= sel;
            r_y_valid  <= 1'b1;
          end
        end
        SCAN: begin
          if (w_scan_entry) begin
            r_y        <= ONE;
            r_scan_idx <= '0;
            r_y_valid  <= 1'b1;
          end else if (w_expire) begin
            r_y         <= {r_y[OUT_W-2:0], r_y[OUT_W-1]};
            r_scan_idx  <= r_scan_idx + 1'b1;
            r_scan_wrap <= w_idx_last;
          end
        end
        default: begin
          r_y       <= '0;
          r_y_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DECODER_ACTIVE_LOW_EN
  assign y = ~r_y;
`else
  assign y = r_y;
`endif

  assign y_valid   = r_y_valid;
  assign scan_idx  = r_scan_idx;
  assign scan_wrap = r_scan_wrap;

endmodule : decoder_scan_nx

// File: tb/tb_decoder_scan_nx.sv
// Directed bench for decoder_scan_nx (SEL_W=2): direct decode, scan timing, dwell reload, idle and reset.
module tb_decoder_scan_nx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic [1:0] sel;
  logic       sel_valid;
  logic       sel_ready;
  logic [7:0] dwell;
  logic [3:0] y;
  logic       y_valid;
  logic [1:0] scan_idx;
  logic       scan_wrap;

  int total = 0;
  int bad   = 0;

  decoder_scan_nx #(.SEL_W(2), .DWELL_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sel      (sel),
    .sel_valid(sel_valid),
    .sel_ready(sel_ready),
    .dwell    (dwell),
    .y        (y),
    .y_valid  (y_valid),
    .scan_idx (scan_idx),
    .scan_wrap(scan_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_y(input logic [3:0] onehot);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~onehot;
`else
    return onehot;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] oh, input logic vld,
                           input logic [1:0] idx, input logic wrap);
    check({tag, ".y"},         32'(y),         32'(exp_y(oh)));
    check({tag, ".y_valid"},   32'(y_valid),   32'(vld));
    check({tag, ".scan_idx"},  32'(scan_idx),  32'(idx));
    check({tag, ".scan_wrap"}, 32'(scan_wrap), 32'(wrap));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0; sel_valid = 1'b0; dwell = 8'd0;
    #1;
    check_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    check("reset.sel_ready", 32'(sel_ready), 32'd0);
    #3 rst = 1'b0;
    step();

    // Direct decode with handshake, then hold without valid.
    en = 1'b1; mode = 1'b0; sel = 2'd2; sel_valid = 1'b1;
    #1 check("direct.sel_ready", 32'(sel_ready), 32'd1);
    step();
    check_out("direct.sel2", 4'b0100, 1'b1, 2'd2, 1'b0);
    sel_valid = 1'b0; sel = 2'd1;
    step();
    check_out("direct.hold1", 4'b0100, 1'b1, 2'd2, 1'b0);
    step();
    check_out("direct.hold2", 4'b0100, 1'b1, 2'd2, 1'b0);
    sel = 2'd3; sel_valid = 1'b1;
    step();
    check_out("direct.sel3", 4'b1000, 1'b1, 2'd3, 1'b0);
    sel_valid = 1'b0;

    // Scan with dwell=0: advance every cycle, wrap pulse only on the second 0001.
    mode = 1'b1; dwell = 8'd0;
    #1 check("scan.sel_ready", 32'(sel_ready), 32'd0);
    step(); check_out("scan0.p0", 4'b0001, 1'b1, 2'd0, 1'b0);
    step(); check_out("scan0.p1", 4'b0010, 1'b1, 2'd1, 1'b0);
    step(); check_out("scan0.p2", 4'b0100, 1'b1, 2'd2, 1'b0);
    step(); check_out("scan0.p3", 4'b1000, 1'b1, 2'd3, 1'b0);
    step(); check_out("scan0.wrap", 4'b0001, 1'b1, 2'd0, 1'b1);
    step(); check_out("scan0.p1b", 4'b0010, 1'b1, 2'd1, 1'b0);

    // Disable mid-scan: outputs clear, index holds; re-enable restarts at bit 0.
    en = 1'b0;
    step(); check_out("idle", 4'b0000, 1'b0, 2'd1, 1'b0);
    en = 1'b1;
    step(); check_out("rescan", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Dwell=3 holds each position 4 cycles; change to 1 mid-position applies at the next one.
    en = 1'b0;
    step();
    en = 1'b1; dwell = 8'd3;
    step(); check_out("dw3.entry", 4'b0001, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); check_out("dw3.hold0", 4'b0001, 1'b1, 2'd0, 1'b0);
    end
    step(); check_out("dw3.p1", 4'b0010, 1'b1, 2'd1, 1'b0);
    step(); check_out("dw3.p1c2", 4'b0010, 1'b1, 2'd1, 1'b0);
    dwell = 8'd1;
    step(); check_out("dw3.p1c3", 4'b0010, 1'b1, 2'd1, 1'b0);
    step(); check_out("dw3.p1c4", 4'b0010, 1'b1, 2'd1, 1'b0);
    step(); check_out("dw1.p2", 4'b0100, 1'b1, 2'd2, 1'b0);
    step(); check_out("dw1.p2c2", 4'b0100, 1'b1, 2'd2, 1'b0);
    step(); check_out("dw1.p3", 4'b1000, 1'b1, 2'd3, 1'b0);
    step(); check_out("dw1.p3c2", 4'b1000, 1'b1, 2'd3, 1'b0);
    step(); check_out("dw1.p0", 4'b0001, 1'b1, 2'd0, 1'b1);
    step(); check_out("dw1.p0c2", 4'b0001, 1'b1, 2'd0, 1'b0);
    step(); check_out("dw1.p1", 4'b0010, 1'b1, 2'd1, 1'b0);
    step(); check_out("dw1.p1c2", 4'b0010, 1'b1, 2'd1, 1'b0);
    step(); check_out("dw1.p2b", 4'b0100, 1'b1, 2'd2, 1'b0);

    // Asynchronous reset mid-scan: clears without a clock edge.
    rst = 1'b1;
    #1 check_out("async_rst", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    step(); check_out("post_rst", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Scan to direct holds the scan value until the first handshake.
    mode = 1'b0; sel_valid = 1'b0;
    step(); check_out("s2d.hold", 4'b0001, 1'b1, 2'd0, 1'b0);
    sel = 2'd1; sel_valid = 1'b1;
    step(); check_out("s2d.sel1", 4'b0010, 1'b1, 2'd1, 1'b0);
    sel_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_decoder_scan_nx
